// File: rtl/fifo_pointer_controller.sv
// fifo_pointer_controller
// Read/write pointer controller for a single-clock FIFO built around an
// external RAM. Each pointer is {lap, index}. The index runs 0..DEPTH-1 and
// the lap bit toggles on every wrap, so any DEPTH >= 2 is supported.
// full, empty and level are registered. They are computed from the next
// pointer values, so they change on the edge after an accept. Misuse shows up
// as one-cycle error pulses in the cycle after the offending request.
//
// Optional feature macro: FIFO_POINTER_CONTROLLER_ALMOST_FLAGS_EN
//   defined   -> adds registered almost_full / almost_empty outputs
//   undefined -> those ports do not exist; the threshold parameters are unused
module fifo_pointer_controller #(
  parameter int DEPTH              = 4,
  parameter int ALMOST_FULL_LEVEL  = 3,
  parameter int ALMOST_EMPTY_LEVEL = 1,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int LW = $clog2(DEPTH + 1)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          flush,
  input  logic          write_request,
  output logic          write_ready,
  output logic          write_enable,
  output logic [AW-1:0] write_address,
  input  logic          read_request,
  output logic          read_ready,
  output logic          read_enable,
  output logic [AW-1:0] read_address,
  output logic          full,
  output logic          empty,
  output logic [LW-1:0] level,
`ifdef FIFO_POINTER_CONTROLLER_ALMOST_FLAGS_EN
  output logic          almost_full,
  output logic          almost_empty,
`endif
  output logic          write_error,
  output logic          read_error
);

  // Elaboration-time parameter sanity checks
  if (DEPTH < 2) begin : g_depth_check
    $error("fifo_pointer_controller: DEPTH must be at least 2");
  end

`ifdef FIFO_POINTER_CONTROLLER_ALMOST_FLAGS_EN
  if ((ALMOST_FULL_LEVEL < 1) || (ALMOST_FULL_LEVEL > DEPTH) ||
      (ALMOST_EMPTY_LEVEL < 0) || (ALMOST_EMPTY_LEVEL > DEPTH - 1)) begin : g_threshold_check
    $error("fifo_pointer_controller: almost-flag thresholds out of range");
  end
`else
  // Thresholds have no effect in this build; only reject values that are never meaningful
  if ((ALMOST_FULL_LEVEL < 0) || (ALMOST_EMPTY_LEVEL < 0)) begin : g_threshold_check
    $error("fifo_pointer_controller: negative almost-flag threshold");
  end
`endif

  localparam logic [AW-1:0] LAST_INDEX = AW'(DEPTH - 1);
  localparam logic [LW-1:0] DEPTH_LW   = LW'(DEPTH);

  // Pointer state, each split into index and lap bit
  logic [AW-1:0] wr_index_q, wr_index_d;
  logic          wr_lap_q,   wr_lap_d;
  logic [AW-1:0] rd_index_q, rd_index_d;
  logic          rd_lap_q,   rd_lap_d;

  // Registered status derived from the next pointer pair
  logic          full_q,  full_d;
  logic          empty_q, empty_d;
  logic [LW-1:0] level_q, level_d;

  // Registered misuse pulses
  logic          write_error_q, write_error_d;
  logic          read_error_q,  read_error_d;

`ifdef FIFO_POINTER_CONTROLLER_ALMOST_FLAGS_EN
  logic          almost_full_q,  almost_full_d;
  logic          almost_empty_q, almost_empty_d;
`endif

  // Accept strobes; flush and reset mask every transfer
  logic          write_accept_s;
  logic          read_accept_s;

  // Next {lap, index}: step the index, wrapping at DEPTH-1 and toggling the lap
  function automatic logic [AW:0] advance_ptr(input logic lap, input logic [AW-1:0] index);
    logic [AW:0] nxt;
    if (index == LAST_INDEX) begin
      nxt = {~lap, {AW{1'b0}}};
    end else begin
      nxt = {lap, index + AW'(1)};
    end
    return nxt;
  endfunction

  // Occupancy from a pointer pair; differing laps mean the writer is one lap ahead
  function automatic logic [LW-1:0] occupancy(input logic          w_lap,
                                              input logic [AW-1:0] w_index,
                                              input logic          r_lap,
                                              input logic [AW-1:0] r_index);
    logic [LW-1:0] cnt;
    if (w_lap == r_lap) begin
      cnt = LW'(w_index) - LW'(r_index);
    end else begin
      cnt = DEPTH_LW - LW'(r_index) + LW'(w_index);
    end
    return cnt;
  endfunction

  // Handshake: readiness comes from registered flags only, so no through-paths exist
  always_comb begin
    write_accept_s = write_request & ~full_q  & ~flush & ~reset;
    read_accept_s  = read_request  & ~empty_q & ~flush & ~reset;
  end

  // Next-state computation for pointers, status and error pulses
  always_comb begin
    wr_index_d = wr_index_q;
    wr_lap_d   = wr_lap_q;
    rd_index_d = rd_index_q;
    rd_lap_d   = rd_lap_q;

    if (flush) begin
      wr_index_d = {AW{1'b0}};
      wr_lap_d   = 1'b0;
      rd_index_d = {AW{1'b0}};
      rd_lap_d   = 1'b0;
    end else begin
      if (write_accept_s) begin
        {wr_lap_d, wr_index_d} = advance_ptr(wr_lap_q, wr_index_q);
      end else begin
        {wr_lap_d, wr_index_d} = {wr_lap_q, wr_index_q};
      end
      if (read_accept_s) begin
        {rd_lap_d, rd_index_d} = advance_ptr(rd_lap_q, rd_index_q);
      end else begin
        {rd_lap_d, rd_index_d} = {rd_lap_q, rd_index_q};
      end
    end

    full_d  = (wr_index_d == rd_index_d) && (wr_lap_d != rd_lap_d);
    empty_d = (wr_index_d == rd_index_d) && (wr_lap_d == rd_lap_d);
    level_d = occupancy(wr_lap_d, wr_index_d, rd_lap_d, rd_index_d);

    // A request against a blocked side is dropped and flagged next cycle
    write_error_d = write_request & full_q;
    read_error_d  = read_request  & empty_q;
  end

`ifdef FIFO_POINTER_CONTROLLER_ALMOST_FLAGS_EN
  // Almost flags follow the next level so they share its latency
  always_comb begin
    almost_full_d  = (level_d >= LW'(ALMOST_FULL_LEVEL));
    almost_empty_d = (level_d <= LW'(ALMOST_EMPTY_LEVEL));
  end
`endif

  // State registers with synchronous reset to an empty FIFO
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_index_q    <= {AW{1'b0}};
      wr_lap_q      <= 1'b0;
      rd_index_q    <= {AW{1'b0}};
      rd_lap_q      <= 1'b0;
      full_q        <= 1'b0;
      empty_q       <= 1'b1;
      level_q       <= {LW{1'b0}};
      write_error_q <= 1'b0;
      read_error_q  <= 1'b0;
    end else begin
      wr_index_q    <= wr_index_d;
      wr_lap_q      <= wr_lap_d;
      rd_index_q    <= rd_index_d;
      rd_lap_q      <= rd_lap_d;
      full_q        <= full_d;
      empty_q       <= empty_d;
      level_q       <= level_d;
      write_error_q <= write_error_d;
      read_error_q  <= read_error_d;
    end
  end

`ifdef FIFO_POINTER_CONTROLLER_ALMOST_FLAGS_EN
  // Almost-flag registers; an empty FIFO is almost empty and not almost full
  always_ff @(posedge clock) begin
    if (reset) begin
      almost_full_q  <= 1'b0;
      almost_empty_q <= 1'b1;
    end else begin
      almost_full_q  <= almost_full_d;
      almost_empty_q <= almost_empty_d;
    end
  end

  assign almost_full  = almost_full_q;
  assign almost_empty = almost_empty_q;
`endif

  assign write_ready   = ~full_q;
  assign read_ready    = ~empty_q;
  assign write_enable  = write_accept_s;
  assign read_enable   = read_accept_s;
  assign write_address = wr_index_q;
  assign read_address  = rd_index_q;
  assign full          = full_q;
  assign empty         = empty_q;
  assign level         = level_q;
  assign write_error   = write_error_q;
  assign read_error    = read_error_q;

endmodule

// File: tb/tb_fifo_pointer_controller.sv
// Directed bench for fifo_pointer_controller: a DEPTH=4 and a DEPTH=3 instance
// share one clock; the random phase uses an occupancy-counter model.
module tb_fifo_pointer_controller;

  logic clock = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  always #5 clock = ~clock;

  // DEPTH=4 instance signals
  logic       flush4, wreq4, rreq4;
  logic       wrdy4, wen4, rrdy4, ren4, full4, empty4, werr4, rerr4;
  logic [1:0] waddr4, raddr4;
  logic [2:0] level4;
`ifdef FIFO_POINTER_CONTROLLER_ALMOST_FLAGS_EN
  logic       af4, ae4;
`endif

  // DEPTH=3 instance signals
  logic       flush3, wreq3, rreq3;
  logic       wrdy3, wen3, rrdy3, ren3, full3, empty3, werr3, rerr3;
  logic [1:0] waddr3, raddr3;
  logic [1:0] level3;
`ifdef FIFO_POINTER_CONTROLLER_ALMOST_FLAGS_EN
  logic       af3, ae3;
`endif

  fifo_pointer_controller #(.DEPTH(4), .ALMOST_FULL_LEVEL(3), .ALMOST_EMPTY_LEVEL(1)) u_dut4 (
    .clock(clock), .reset(reset), .flush(flush4),
    .write_request(wreq4), .write_ready(wrdy4), .write_enable(wen4), .write_address(waddr4),
    .read_request(rreq4), .read_ready(rrdy4), .read_enable(ren4), .read_address(raddr4),
    .full(full4), .empty(empty4), .level(level4),
`ifdef FIFO_POINTER_CONTROLLER_ALMOST_FLAGS_EN
    .almost_full(af4), .almost_empty(ae4),
`endif
    .write_error(werr4), .read_error(rerr4)
  );

  fifo_pointer_controller #(.DEPTH(3), .ALMOST_FULL_LEVEL(3), .ALMOST_EMPTY_LEVEL(1)) u_dut3 (
    .clock(clock), .reset(reset), .flush(flush3),
    .write_request(wreq3), .write_ready(wrdy3), .write_enable(wen3), .write_address(waddr3),
    .read_request(rreq3), .read_ready(rrdy3), .read_enable(ren3), .read_address(raddr3),
    .full(full3), .empty(empty3), .level(level3),
`ifdef FIFO_POINTER_CONTROLLER_ALMOST_FLAGS_EN
    .almost_full(af3), .almost_empty(ae3),
`endif
    .write_error(werr3), .read_error(rerr3)
  );

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    flush4 = 1'b0; wreq4 = 1'b0; rreq4 = 1'b0;
    flush3 = 1'b0; wreq3 = 1'b0; rreq3 = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    total++; if (empty4 !== 1'b1) begin bad++; $display("FAIL reset_empty4 got=%0b exp=1", empty4); end
    total++; if (full4 !== 1'b0) begin bad++; $display("FAIL reset_full4 got=%0b exp=0", full4); end
    total++; if (level4 !== 3'd0) begin bad++; $display("FAIL reset_level4 got=%0d exp=0", level4); end
    total++; if (rrdy4 !== 1'b0) begin bad++; $display("FAIL reset_rrdy4 got=%0b exp=0", rrdy4); end
    total++; if (wrdy4 !== 1'b1) begin bad++; $display("FAIL reset_wrdy4 got=%0b exp=1", wrdy4); end
    total++; if (waddr4 !== 2'd0 || raddr4 !== 2'd0) begin bad++; $display("FAIL reset_addr4 got=%0d/%0d exp=0/0", waddr4, raddr4); end
    total++; if (werr4 !== 1'b0 || rerr4 !== 1'b0) begin bad++; $display("FAIL reset_err4 got=%0b/%0b exp=0/0", werr4, rerr4); end
    total++; if (empty3 !== 1'b1 || full3 !== 1'b0 || level3 !== 2'd0) begin
      bad++; $display("FAIL reset_flags3 got e=%0b f=%0b l=%0d exp e=1 f=0 l=0", empty3, full3, level3);
    end
`ifdef FIFO_POINTER_CONTROLLER_ALMOST_FLAGS_EN
    total++; if (af4 !== 1'b0 || ae4 !== 1'b1) begin bad++; $display("FAIL reset_almost4 got af=%0b ae=%0b exp af=0 ae=1", af4, ae4); end
`endif
  endtask

  // Four writes fill DEPTH=4; a fifth is rejected and flagged
  task automatic test_fill;
    for (int i = 0; i < 4; i++) begin
      wreq4 = 1'b1;
      #1;
      total++; if (wen4 !== 1'b1) begin bad++; $display("FAIL fill_wen i=%0d got=%0b exp=1", i, wen4); end
      total++; if (waddr4 !== i[1:0]) begin bad++; $display("FAIL fill_waddr i=%0d got=%0d exp=%0d", i, waddr4, i); end
      tick();
      total++; if (level4 !== 3'(i + 1)) begin bad++; $display("FAIL fill_level i=%0d got=%0d exp=%0d", i, level4, i + 1); end
      total++; if (full4 !== (i == 3)) begin bad++; $display("FAIL fill_full i=%0d got=%0b exp=%0b", i, full4, (i == 3)); end
`ifdef FIFO_POINTER_CONTROLLER_ALMOST_FLAGS_EN
      total++; if (af4 !== (i >= 2) || ae4 !== (i == 0)) begin
        bad++; $display("FAIL fill_almost i=%0d got af=%0b ae=%0b exp af=%0b ae=%0b", i, af4, ae4, (i >= 2), (i == 0));
      end
`endif
    end
    total++; if (waddr4 !== 2'd0) begin bad++; $display("FAIL fill_wrap_waddr got=%0d exp=0", waddr4); end
    #1;
    total++; if (wen4 !== 1'b0 || wrdy4 !== 1'b0) begin bad++; $display("FAIL overflow_wen got wen=%0b rdy=%0b exp 0/0", wen4, wrdy4); end
    tick();
    wreq4 = 1'b0;
    total++; if (werr4 !== 1'b1) begin bad++; $display("FAIL overflow_werr got=%0b exp=1", werr4); end
    total++; if (level4 !== 3'd4) begin bad++; $display("FAIL overflow_level got=%0d exp=4", level4); end
    tick();
    total++; if (werr4 !== 1'b0) begin bad++; $display("FAIL overflow_werr_clear got=%0b exp=0", werr4); end
  endtask

  // Full with write+read: only the read goes; then drain; then empty with write+read
  task automatic test_full_empty_rw;
    wreq4 = 1'b1; rreq4 = 1'b1;
    #1;
    total++; if (wen4 !== 1'b0 || ren4 !== 1'b1) begin bad++; $display("FAIL fullrw_en got w=%0b r=%0b exp w=0 r=1", wen4, ren4); end
    tick();
    total++; if (level4 !== 3'd3 || full4 !== 1'b0) begin bad++; $display("FAIL fullrw_level got l=%0d f=%0b exp l=3 f=0", level4, full4); end
    total++; if (werr4 !== 1'b1) begin bad++; $display("FAIL fullrw_werr got=%0b exp=1", werr4); end
    wreq4 = 1'b0;
    for (int i = 1; i < 4; i++) begin
      #1;
      total++; if (ren4 !== 1'b1 || raddr4 !== i[1:0]) begin bad++; $display("FAIL drain_raddr i=%0d got en=%0b a=%0d exp en=1 a=%0d", i, ren4, raddr4, i); end
      tick();
    end
    total++; if (empty4 !== 1'b1 || level4 !== 3'd0 || raddr4 !== 2'd0) begin
      bad++; $display("FAIL drain_empty got e=%0b l=%0d ra=%0d exp e=1 l=0 ra=0", empty4, level4, raddr4);
    end
    wreq4 = 1'b1; rreq4 = 1'b1;
    #1;
    total++; if (wen4 !== 1'b1 || ren4 !== 1'b0) begin bad++; $display("FAIL emptyrw_en got w=%0b r=%0b exp w=1 r=0", wen4, ren4); end
    tick();
    wreq4 = 1'b0; rreq4 = 1'b0;
    total++; if (level4 !== 3'd1 || empty4 !== 1'b0) begin bad++; $display("FAIL emptyrw_level got l=%0d e=%0b exp l=1 e=0", level4, empty4); end
    total++; if (rerr4 !== 1'b1) begin bad++; $display("FAIL emptyrw_rerr got=%0b exp=1", rerr4); end
    tick();
  endtask

  // Reach level 2 with both pointers away from 0, then flush with a write pending
  task automatic test_flush;
    wreq4 = 1'b1;
    tick();
    tick();
    wreq4 = 1'b0; rreq4 = 1'b1;
    tick();
    rreq4 = 1'b0;
    total++; if (level4 !== 3'd2 || waddr4 !== 2'd3 || raddr4 !== 2'd1) begin
      bad++; $display("FAIL preflush got l=%0d wa=%0d ra=%0d exp l=2 wa=3 ra=1", level4, waddr4, raddr4);
    end
    flush4 = 1'b1; wreq4 = 1'b1;
    #1;
    total++; if (wen4 !== 1'b0) begin bad++; $display("FAIL flush_wen got=%0b exp=0", wen4); end
    tick();
    flush4 = 1'b0; wreq4 = 1'b0;
    total++; if (level4 !== 3'd0 || empty4 !== 1'b1 || full4 !== 1'b0) begin
      bad++; $display("FAIL flush_state got l=%0d e=%0b f=%0b exp l=0 e=1 f=0", level4, empty4, full4);
    end
    total++; if (waddr4 !== 2'd0 || raddr4 !== 2'd0) begin bad++; $display("FAIL flush_addr got=%0d/%0d exp=0/0", waddr4, raddr4); end
  endtask

  // DEPTH=3: fill and drain three times so both lap bits toggle through every pairing
  task automatic test_wrap3;
    for (int lap = 0; lap < 3; lap++) begin
      for (int i = 0; i < 3; i++) begin
        wreq3 = 1'b1;
        #1;
        total++; if (wen3 !== 1'b1 || waddr3 !== i[1:0]) begin bad++; $display("FAIL wrap3_w lap=%0d i=%0d got en=%0b a=%0d exp en=1 a=%0d", lap, i, wen3, waddr3, i); end
        tick();
        total++; if (level3 !== 2'(i + 1) || full3 !== (i == 2) || empty3 !== 1'b0) begin
          bad++; $display("FAIL wrap3_wflags lap=%0d i=%0d got l=%0d f=%0b e=%0b exp l=%0d f=%0b e=0", lap, i, level3, full3, empty3, i + 1, (i == 2));
        end
      end
      wreq3 = 1'b0;
      total++; if (waddr3 !== 2'd0 || wrdy3 !== 1'b0) begin bad++; $display("FAIL wrap3_wwrap lap=%0d got a=%0d rdy=%0b exp a=0 rdy=0", lap, waddr3, wrdy3); end
      for (int i = 0; i < 3; i++) begin
        rreq3 = 1'b1;
        #1;
        total++; if (ren3 !== 1'b1 || raddr3 !== i[1:0]) begin bad++; $display("FAIL wrap3_r lap=%0d i=%0d got en=%0b a=%0d exp en=1 a=%0d", lap, i, ren3, raddr3, i); end
        tick();
        total++; if (level3 !== 2'(2 - i) || empty3 !== (i == 2) || full3 !== 1'b0) begin
          bad++; $display("FAIL wrap3_rflags lap=%0d i=%0d got l=%0d e=%0b f=%0b exp l=%0d e=%0b f=0", lap, i, level3, empty3, full3, 2 - i, (i == 2));
        end
      end
      rreq3 = 1'b0;
      total++; if (raddr3 !== 2'd0 || rrdy3 !== 1'b0 || werr3 !== 1'b0 || rerr3 !== 1'b0) begin
        bad++; $display("FAIL wrap3_rwrap lap=%0d got a=%0d rdy=%0b we=%0b re=%0b exp 0/0/0/0", lap, raddr3, rrdy3, werr3, rerr3);
      end
    end
  endtask

  // Random traffic on DEPTH=4 against an occupancy-counter model
  task automatic test_random;
    int  cnt = 0, wa = 0, ra = 0;
    bit  exp_werr = 1'b0, exp_rerr = 1'b0;
    bit  fl, wr, rd, exp_wen, exp_ren;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      fl = ($urandom_range(0, 31) == 0);
      wr = $urandom_range(0, 1) == 1;
      rd = $urandom_range(0, 1) == 1;
      flush4 = fl; wreq4 = wr; rreq4 = rd;
      #1;
      exp_wen = wr && (cnt < 4) && !fl;
      exp_ren = rd && (cnt > 0) && !fl;
      total++; if (wen4 !== exp_wen || ren4 !== exp_ren) begin bad++; $display("FAIL rnd_en c=%0d got w=%0b r=%0b exp w=%0b r=%0b", c, wen4, ren4, exp_wen, exp_ren); end
      total++; if (level4 !== 3'(cnt)) begin bad++; $display("FAIL rnd_level c=%0d got=%0d exp=%0d", c, level4, cnt); end
      total++; if (full4 !== (cnt == 4) || empty4 !== (cnt == 0) || wrdy4 !== (cnt != 4) || rrdy4 !== (cnt != 0)) begin
        bad++; $display("FAIL rnd_flags c=%0d got f=%0b e=%0b wr=%0b rr=%0b cnt=%0d", c, full4, empty4, wrdy4, rrdy4, cnt);
      end
      total++; if (waddr4 !== 2'(wa) || raddr4 !== 2'(ra)) begin bad++; $display("FAIL rnd_addr c=%0d got=%0d/%0d exp=%0d/%0d", c, waddr4, raddr4, wa, ra); end
      total++; if (werr4 !== exp_werr || rerr4 !== exp_rerr) begin bad++; $display("FAIL rnd_err c=%0d got=%0b/%0b exp=%0b/%0b", c, werr4, rerr4, exp_werr, exp_rerr); end
`ifdef FIFO_POINTER_CONTROLLER_ALMOST_FLAGS_EN
      total++; if (af4 !== (cnt >= 3) || ae4 !== (cnt <= 1)) begin bad++; $display("FAIL rnd_almost c=%0d got af=%0b ae=%0b cnt=%0d", c, af4, ae4, cnt); end
`endif
      exp_werr = wr && (cnt == 4);
      exp_rerr = rd && (cnt == 0);
      if (fl) begin
        cnt = 0; wa = 0; ra = 0;
      end else begin
        if (exp_wen) begin wa = (wa + 1) % 4; cnt++; end
        if (exp_ren) begin ra = (ra + 1) % 4; cnt--; end
      end
      tick();
    end
    flush4 = 1'b0; wreq4 = 1'b0; rreq4 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_fill();
    test_full_empty_rw();
    test_flush();
    test_wrap3();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
